// File: rtl/prbs_pattern_engine.sv
// rtl/prbs_pattern_engine.sv - PRBS/user pattern generator with bit-rate NCO, bursts, error injection and slew-limited DAC drive
module prbs_pattern_engine #(
    parameter int DAC_W   = 16,
    parameter int ACC_W   = 32,
    parameter int USER_W  = 32,
    parameter int BURST_W = 16
) (
    input  logic                    dac_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [3:0]              pn_select,
    input  logic [ACC_W-1:0]        bit_rate_inc,
    input  logic [USER_W-1:0]       user_pattern,
    input  logic [$clog2(USER_W):0] user_len,
    input  logic [BURST_W-1:0]      burst_len,
    input  logic [DAC_W-1:0]        level_high,
    input  logic [DAC_W-1:0]        level_low,
    input  logic [DAC_W-1:0]        slew_step,
    input  logic                    err_inject,
    output logic [DAC_W-1:0]        dac_data,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    sync_out,
    output logic                    busy,
    output logic                    burst_done,
    output logic [30:0]             lfsr_state
);
    localparam int UI_W = $clog2(USER_W);
    localparam int UL_W = UI_W + 1;
    localparam logic [UL_W-1:0] ULEN_ONE = 1;
    localparam logic [UL_W-1:0] ULEN_MAX = UL_W'(USER_W);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [30:0]        lfsr;
    logic [UI_W-1:0]    uidx;
    logic [UL_W-1:0]    ulen_q;
    logic [2:0]         mode;
    logic [BURST_W-1:0] count;
    logic               err_pend;
    logic               by_burst;

    // Seed doubles as the width mask; user mode (7) keeps the LFSR at zero.
    function automatic logic [30:0] seed_of(input logic [2:0] m);
        case (m)
            3'd0:    return 31'h0000007F;
            3'd1:    return 31'h000001FF;
            3'd2:    return 31'h000007FF;
            3'd3:    return 31'h00007FFF;
            3'd4:    return 31'h000FFFFF;
            3'd5:    return 31'h007FFFFF;
            3'd6:    return 31'h7FFFFFFF;
            default: return 31'h0;
        endcase
    endfunction

    function automatic logic lfsr_fb(input logic [30:0] l, input logic [2:0] m);
        case (m)
            3'd0:    return l[6] ^ l[5];
            3'd1:    return l[8] ^ l[4];
            3'd2:    return l[10] ^ l[8];
            3'd3:    return l[14] ^ l[13];
            3'd4:    return l[19] ^ l[2];
            3'd5:    return l[22] ^ l[17];
            3'd6:    return l[30] ^ l[27];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lfsr_msb(input logic [30:0] l, input logic [2:0] m);
        case (m)
            3'd0:    return l[6];
            3'd1:    return l[8];
            3'd2:    return l[10];
            3'd3:    return l[14];
            3'd4:    return l[19];
            3'd5:    return l[22];
            3'd6:    return l[30];
            default: return 1'b0;
        endcase
    endfunction

    logic [ACC_W:0]   acc_sum;
    logic             tick;
    logic [2:0]       mode_in;
    logic [UL_W-1:0]  ulen_in;
    logic             err_now;
    logic [UI_W-1:0]  uidx_nx;
    logic [30:0]      lfsr_nx;
    logic             next_bit;
    logic             next_sync;
    logic             first_bit;

    always_comb begin
        acc_sum   = {1'b0, acc} + {1'b0, bit_rate_inc};
        tick      = acc_sum[ACC_W];
        mode_in   = pn_select[3] ? 3'd0 : pn_select[2:0];
        err_now   = err_pend | err_inject;
        first_bit = (mode_in == 3'd7) ? user_pattern[0] : 1'b1;
        if (user_len == '0)
            ulen_in = ULEN_ONE;
        else if (user_len > ULEN_MAX)
            ulen_in = ULEN_MAX;
        else
            ulen_in = user_len;
        uidx_nx = ({1'b0, uidx} == ulen_q - ULEN_ONE) ? '0 : uidx + UI_W'(1);
        lfsr_nx = {lfsr[29:0], lfsr_fb(lfsr, mode)} & seed_of(mode);
        if (mode == 3'd7) begin
            next_bit  = user_pattern[uidx_nx];
            next_sync = (uidx_nx == '0);
        end else begin
            next_bit  = lfsr_msb(lfsr_nx, mode);
            next_sync = (lfsr_nx == seed_of(mode));
        end
    end

    // Slew limiter: work one bit wider so neither the gap nor the step can wrap.
    logic [DAC_W-1:0] target;
    logic [DAC_W-1:0] dac_nx;
    logic [DAC_W:0]   tx, dx, sx, diff, dac_up, dac_dn;
    logic             up;

    always_comb begin
        target = (state == RUN && bit_out) ? level_high : level_low;
        tx     = {1'b0, target};
        dx     = {1'b0, dac_data};
        sx     = {1'b0, slew_step};
        up     = (tx >= dx);
        diff   = up ? (tx - dx) : (dx - tx);
        dac_up = dx + sx;
        dac_dn = dx - sx;
        if (slew_step == '0 || diff <= sx)
            dac_nx = target;
        else if (up)
            dac_nx = dac_up[DAC_W-1:0];
        else
            dac_nx = dac_dn[DAC_W-1:0];
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            lfsr       <= '0;
            uidx       <= '0;
            ulen_q     <= '0;
            mode       <= '0;
            count      <= '0;
            err_pend   <= 1'b0;
            by_burst   <= 1'b0;
            dac_data   <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            sync_out   <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            sync_out   <= 1'b0;
            burst_done <= 1'b0;
            dac_data   <= dac_nx;
            case (state)
                IDLE: begin
                    if (start && enable) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        mode      <= mode_in;
                        ulen_q    <= ulen_in;
                        lfsr      <= seed_of(mode_in);
                        uidx      <= '0;
                        acc       <= '0;
                        count     <= BURST_W'(1);
                        by_burst  <= 1'b0;
                        bit_out   <= first_bit ^ err_now;
                        err_pend  <= 1'b0;
                        bit_valid <= 1'b1;
                        sync_out  <= 1'b1;
                    end else begin
                        err_pend <= err_now;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state    <= SETTLE;
                        bit_out  <= 1'b0;
                        err_pend <= err_now;
                    end else begin
                        acc <= acc_sum[ACC_W-1:0];
                        if (tick && burst_len != '0 && count == burst_len) begin
                            state    <= SETTLE;
                            bit_out  <= 1'b0;
                            by_burst <= 1'b1;
                            err_pend <= err_now;
                        end else if (tick) begin
                            lfsr      <= lfsr_nx;
                            uidx      <= uidx_nx;
                            bit_out   <= next_bit ^ err_now;
                            err_pend  <= 1'b0;
                            bit_valid <= 1'b1;
                            sync_out  <= next_sync;
                            if (count != '1)
                                count <= count + BURST_W'(1);
                        end else begin
                            err_pend <= err_now;
                        end
                    end
                end
                SETTLE: begin
                    err_pend <= err_now;
                    if (dac_data == level_low) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        burst_done <= by_burst;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lfsr_state = lfsr;

endmodule

// File: doc/prbs_pattern_engine.md
Name: prbs_pattern_engine

Overview:
Parametrised successor of the single-channel PRBS path. It selects a PRBS or user pattern, times bits from a phase-accumulator bit-rate NCO, and adds burst mode, error injection, sequence-sync marking and a slew-limited DAC output with programmable high and low levels. It runs in the dac_clk domain and drives one DAC channel's data mux.

Parameters:
DAC_W, 16, DAC sample width (unsigned offset-binary)
ACC_W, 32, NCO phase accumulator / increment width
USER_W, 32, maximum user-pattern length in bits
BURST_W, 16, burst bit counter width

Ports:
dac_clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; low while running aborts the sequence
start  in  1  1-cycle pulse; begins a sequence from IDLE
pn_select  in  4  0=PN7(x7+x6+1) 1=PN9(x9+x5) 2=PN11(x11+x9) 3=PN15(x15+x14) 4=PN20(x20+x3) 5=PN23(x23+x18) 6=PN31(x31+x28) 7=user; 8-15 decode as PN7
bit_rate_inc  in  ACC_W  NCO increment; one bit per accumulator carry
user_pattern  in  USER_W  user bits, bit 0 sent first
user_len  in  $clog2(USER_W)+1  user length; 0 decodes as 1, >USER_W clamps to USER_W
burst_len  in  BURST_W  bits per burst; 0 = continuous
level_high  in  DAC_W  DAC code for a 1
level_low  in  DAC_W  DAC code for a 0 and for idle
slew_step  in  DAC_W  maximum code change per cycle; 0 = instantaneous step
err_inject  in  1  pulse; inverts the next emitted bit
dac_data  out  DAC_W  shaped output
bit_out  out  1  current pattern bit, after any injected error
bit_valid  out  1  1-cycle pulse when a new bit is loaded
sync_out  out  1  pulse with bit_valid on the first bit of each pattern period
busy  out  1  high in RUN and SETTLE
burst_done  out  1  1-cycle pulse on normal burst completion
lfsr_state  out  31  debug copy of the LFSR; upper unused bits are 0

Behaviour:
- Reset (synchronous, active-high): state=IDLE. dac_data, bit_out, bit_valid, sync_out, busy, burst_done, accumulator and counters all reset to 0. lfsr_state resets to 0. Error-pending flag clears.
- pn_select and user_len are latched on start and ignored mid-run. bit_rate_inc, levels and slew_step are live.
- IDLE:
  - target = level_low.
  - start while enable=1 moves to RUN next cycle. start while enable=0 is ignored.
  - start in RUN or SETTLE is ignored.
- Entering RUN (cycle t+1 after start at t):
  - LFSR loads all-ones in its low N bits; user index = 0; accumulator = 0.
  - The first bit (LFSR bit N-1, or user_pattern[0]) is loaded at t+1 with bit_valid=1, sync_out=1, and burst count = 1.
- RUN:
  - Each cycle: acc <= acc + bit_rate_inc (mod 2^ACC_W); a carry-out is a tick.
  - On a tick, if burst_len != 0 and count == burst_len, go to SETTLE with no new bit.
  - Otherwise on a tick, load the next bit with bit_valid=1 and increment count (saturating).
  - LFSR is Fibonacci, shifting left: new LSB = XOR of the two tap bits; output is bit N-1.
  - The user index wraps from user_len-1 to 0.
  - sync_out pulses when the emitted bit is LFSR seed state or user index 0: every 2^N-1 bits for PRBS, every user_len bits for user mode.
  - bit_rate_inc = 0 produces no ticks; the first bit is held indefinitely.
- Error injection:
  - err_inject sets a pending flag, cleared when it is consumed.
  - The next loaded bit (including one loaded in the same cycle as the pulse) is XOR-inverted.
  - The LFSR and user index are unaffected, so the sequence resumes uncorrupted.
  - err_inject in IDLE or SETTLE stays pending until the next run's first bit.
- enable low in RUN forces SETTLE next cycle with no burst_done. Reset mid-run returns everything to reset values in one cycle.
- SETTLE:
  - target = level_low; bit_out = 0.
  - When dac_data == level_low, go to IDLE. burst_done pulses on that transition only if RUN ended by burst completion.
- Slew, every cycle in every state except reset:
  - In RUN, target = bit_out ? level_high : level_low.
  - If slew_step == 0 or |target - dac_data| <= slew_step, then dac_data <= target.
  - Otherwise dac_data moves by ±slew_step.
  - Difference and sum are computed at DAC_W+1 bits, so the output never wraps.
  - Output latency is one cycle from bit_out change to first dac_data movement.
- busy = (state != IDLE).

Test Plan:
- PN7, bit_rate_inc=2^31, burst_len=0, slew_step=0, high=0xFFFF, low=0 -> bit every 2 cycles; first 7 bits 1, 8th bit 0; 64 ones and 63 zeros per period; sync_out every 254 cycles; dac_data toggles between 0xFFFF and 0x0000.
- pn_select=7, user_pattern=0xB, user_len=4, burst_len=8 -> bits 1,1,0,1,1,1,0,1 with sync_out on bits 1 and 5; SETTLE follows, then burst_done single pulse, busy falls the same cycle.
- low=0x1000, high=0xF000, slew_step=0x1000, bit 0->1 -> dac_data rises by 0x1000 per cycle and reaches 0xF000 after 14 cycles; step 0x3000 gives 0x4000, 0x7000, ... 0xD000, then clamps to 0xF000 (no overshoot).
- high=0xFFFF, slew_step=0x6000 from 0 -> 0x6000, 0xC000, 0xFFFF; no wrap.
- PN15 run with err_inject on the cycle of bit 10 -> only bit 10 inverted versus the golden sequence; bit 11 onward matches the golden sequence.
- Abort and edge cases:
  - enable low mid-burst -> SETTLE, no burst_done.
  - Reset mid-run -> all outputs 0 the next cycle.
  - start while busy -> ignored.
  - bit_rate_inc=0 -> first bit only, held.
